// File: rtl/paso_pkg.sv
// Shared definitions for the word-to-byte serializer datapath.
// Provides word/byte geometry, the default idle byte, the byte-index
// type, and a helper that picks one byte of a word (MSB byte first).
package paso_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;

  localparam logic [BYTE_W-1:0] PASO_IDLE_BYTE_DEFAULT = 8'hBC;

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

  // Byte idx of a word, index 0 being the most significant byte.
  function automatic logic [BYTE_W-1:0] word_byte(input logic [WORD_W-1:0] w,
                                                  input byte_idx_t         idx);
    logic [BYTE_W-1:0] b;
    b = w[7:0];
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/paso_word_hold.sv
// One-entry word holding register with a full flag.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_en_i       : store data_i and mark full
//   take_i        : entry consumed this cycle, clear full
//   data_i        : word to store
//   data_o        : stored word
//   full_o        : entry holds a valid word
module paso_word_hold
  import paso_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic              take_i,
  input  logic [WORD_W-1:0] data_i,
  output logic [WORD_W-1:0] data_o,
  output logic              full_o
);

  logic [WORD_W-1:0] data_q, data_d;
  logic              full_q, full_d;

  // A write wins over a take; the parent never issues both together.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (take_i) full_d = 1'b0;
    if (wr_en_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/paso32bto8b.sv
// Word-to-byte serializer: 32-bit words in on valid/ready, four bytes out
// MSB first with a per-byte valid. A shifter plus one holding register
// sustain one word every four cycles without output gaps.
// Optional macro PASO32BTO8B_IDLE_EN: drive IDLE_BYTE on data_out while
// valid_out is low (including reset); otherwise data_out holds the last byte.
// Ports:
//   clk_4f    : byte-rate clock
//   reset     : asynchronous active-low reset
//   data_in   : word to serialize
//   valid_in  : data_in valid
//   in_ready  : holding register empty, word taken when valid_in is high
//   data_out  : serialized byte (registered)
//   valid_out : data_out carries a valid byte (registered)
module paso32bto8b
  import paso_pkg::*;
#(
  parameter logic [BYTE_W-1:0] IDLE_BYTE = PASO_IDLE_BYTE_DEFAULT
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              in_ready,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out
);

`ifdef PASO32BTO8B_IDLE_EN
  localparam bit IDLE_EN = 1'b1;
`else
  localparam bit IDLE_EN = 1'b0;
`endif

  localparam logic [BYTE_W-1:0] RESET_BYTE = IDLE_EN ? IDLE_BYTE : '0;

  logic [WORD_W-1:0] shift_reg_q, shift_reg_d;
  logic              shift_valid_q, shift_valid_d;
  byte_idx_t         byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;

  logic              hold_wr, hold_take, hold_full;
  logic [WORD_W-1:0] hold_data;
  logic              accept, last_byte;

  // Ready depends only on registered state and the reset pin.
  assign in_ready  = reset && !hold_full;
  assign accept    = valid_in && in_ready;
  assign last_byte = shift_valid_q && (byte_cnt_q == LAST_BYTE_IDX);

  paso_word_hold u_hold (
    .clk_i   (clk_4f),
    .rst_ni  (reset),
    .wr_en_i (hold_wr),
    .take_i  (hold_take),
    .data_i  (data_in),
    .data_o  (hold_data),
    .full_o  (hold_full)
  );

  // Shifter, byte counter and output byte selection.
  always_comb begin
    shift_reg_d   = shift_reg_q;
    shift_valid_d = shift_valid_q;
    byte_cnt_d    = byte_cnt_q;
    hold_wr       = 1'b0;
    hold_take     = 1'b0;
    valid_out_d   = shift_valid_q;
    data_out_d    = IDLE_EN ? IDLE_BYTE : data_out_q;

    if (shift_valid_q) begin
      data_out_d = word_byte(shift_reg_q, byte_cnt_q);
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    // Held word moves in on the last byte; ready was low, so no accept now.
    if (last_byte) begin
      if (hold_full) begin
        shift_reg_d = hold_data;
        hold_take   = 1'b1;
      end else if (!accept) begin
        shift_valid_d = 1'b0;
      end
    end

    // Empty or draining shifter takes the word directly, bypassing the hold.
    if (accept) begin
      if (!shift_valid_q || last_byte) begin
        shift_reg_d   = data_in;
        shift_valid_d = 1'b1;
        byte_cnt_d    = '0;
      end else begin
        hold_wr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      shift_reg_q   <= '0;
      shift_valid_q <= 1'b0;
      byte_cnt_q    <= '0;
      data_out_q    <= RESET_BYTE;
      valid_out_q   <= 1'b0;
    end else begin
      shift_reg_q   <= shift_reg_d;
      shift_valid_q <= shift_valid_d;
      byte_cnt_q    <= byte_cnt_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;

endmodule
